// File: rtl/display_pkg.sv
// Shared types, widths and DIN field layout for the seven-segment display writer.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int NUM_DIGITS = 8;
    localparam int ADDR_W     = 3;
    localparam int DIN_W      = 6;

    localparam int DIN_EN     = 5;
    localparam int DIN_NIB_HI = 4;
    localparam int DIN_NIB_LO = 1;
    localparam int DIN_DP     = 0;

    // A disabled digit always carries a zero nibble so a blanked digit is fully defined.
    function automatic logic [DIN_W-1:0] pack_din(input logic en, input logic [3:0] nib,
                                                  input logic dp);
        logic [DIN_W-1:0] d;
        d                         = '0;
        d[DIN_EN]                 = en;
        d[DIN_NIB_HI:DIN_NIB_LO]  = en ? nib : 4'h0;
        d[DIN_DP]                 = dp;
        return d;
    endfunction

endpackage

// File: rtl/display_writer_if.sv
// CPU-side handshake plus display write bus of the display writer.
// slave = the writer's view, master = the CPU/display-model view.
interface display_writer_if;
    import display_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [31:0]       value;
    logic [7:0]        dp_mask;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] WADD;
    logic [DIN_W-1:0]  DIN;
    logic              enter;

    modport slave (
        input  in_valid, value, dp_mask,
        output in_ready, busy, done, WADD, DIN, enter
    );

    modport master (
        output in_valid, value, dp_mask,
        input  in_ready, busy, done, WADD, DIN, enter
    );

endinterface

// File: rtl/display_writer_lead_nz_detect.sv
// Highest non-zero nibble index of a 32-bit word (0 when the word is zero).
// Only compiled when DISPLAY_WRITER_LZB_EN is defined.
`ifdef DISPLAY_WRITER_LZB_EN
module lead_nz_detect (
    input  logic [31:0] value,
    output logic [2:0]  msd
);

    always_comb begin
        msd = '0;
        for (int i = 1; i < 8; i++) begin
            if (value[i*4 +: 4] != 4'h0) msd = 3'(i);
        end
    end

endmodule
`endif

// File: rtl/display_writer.sv
// Serialises a 32-bit hex word plus decimal-point mask into 8 display digit writes.
// Define DISPLAY_WRITER_LZB_EN to enable leading-zero blanking.
module display_writer
    import display_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int HOLD_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    display_writer_if.slave  bus
);

    localparam logic [1:0]        S_IDLE    = IDLE;
    localparam logic [1:0]        S_WRITE   = WRITE;
    localparam logic [1:0]        S_HOLD    = HOLD;
    localparam logic [1:0]        S_DONE    = DONE;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_DIGITS - 1);
    localparam logic [3:0]        HOLD_LOAD = 4'(HOLD_CYCLES - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_nxt;
    logic [3:0]        hold_cnt;
    logic [31:0]       value_r;
    logic [7:0]        dp_r;
    logic              en_nxt;
    logic              accept;

    assign accept  = bus.in_valid && (state == S_IDLE);
    assign idx_nxt = idx + 1'b1;

`ifdef DISPLAY_WRITER_LZB_EN
    logic [2:0] msd_in;
    logic [2:0] msd_r;

    lead_nz_detect u_lead_nz_detect (
        .value (bus.value),
        .msd   (msd_in)
    );

    // Digits above the most-significant non-zero nibble are blanked.
    assign en_nxt = (idx_nxt <= msd_r);

    always_ff @(posedge clk) begin
        if (accept) msd_r <= msd_in;
    end
`else
    assign en_nxt = 1'b1;
`endif

    // Word capture: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            value_r <= bus.value;
            dp_r    <= bus.dp_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            idx          <= '0;
            hold_cnt     <= '0;
            bus.WADD     <= '0;
            bus.DIN      <= '0;
            bus.enter    <= 1'b0;
            bus.done     <= 1'b0;
            bus.busy     <= 1'b0;
            bus.in_ready <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        // Digit 0 is always enabled, so no detector result is needed here.
                        state        <= S_WRITE;
                        idx          <= '0;
                        bus.enter    <= 1'b1;
                        bus.WADD     <= '0;
                        bus.DIN      <= pack_din(1'b1, bus.value[3:0], bus.dp_mask[0]);
                        bus.busy     <= 1'b1;
                        bus.in_ready <= 1'b0;
                    end
                end
                S_WRITE: begin
                    bus.enter <= 1'b0;
                    hold_cnt  <= HOLD_LOAD;
                    state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (hold_cnt != 4'd0) begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end else if (idx == LAST_IDX) begin
                        state    <= S_DONE;
                        bus.done <= 1'b1;
                    end else begin
                        idx       <= idx_nxt;
                        state     <= S_WRITE;
                        bus.enter <= 1'b1;
                        bus.WADD  <= idx_nxt;
                        bus.DIN   <= pack_din(en_nxt, value_r[{idx_nxt, 2'b00} +: 4],
                                              dp_r[idx_nxt]);
                    end
                end
                S_DONE: begin
                    bus.done     <= 1'b0;
                    bus.busy     <= 1'b0;
                    bus.in_ready <= 1'b1;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_display_writer.sv
// Directed self-checking bench for display_writer: HOLD_CYCLES=1 and HOLD_CYCLES=3 instances.
module tb_display_writer;
    import display_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n0;
    logic rst_n1;

    display_writer_if bus0 ();
    display_writer_if bus1 ();

    display_writer #(.NUM_DIGITS(8), .HOLD_CYCLES(1)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n0),
        .bus   (bus0.slave)
    );

    display_writer #(.NUM_DIGITS(8), .HOLD_CYCLES(3)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n1),
        .bus   (bus1.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic [31:0] val,
                         input logic [7:0] dp);
        if (sel) begin
            bus1.in_valid = v;
            bus1.value    = val;
            bus1.dp_mask  = dp;
        end else begin
            bus0.in_valid = v;
            bus0.value    = val;
            bus0.dp_mask  = dp;
        end
    endtask

    task automatic snap(input bit sel, output logic en, output logic [2:0] wa,
                        output logic [5:0] din, output logic dn, output logic bz,
                        output logic rdy);
        en  = sel ? bus1.enter    : bus0.enter;
        wa  = sel ? bus1.WADD     : bus0.WADD;
        din = sel ? bus1.DIN      : bus0.DIN;
        dn  = sel ? bus1.done     : bus0.done;
        bz  = sel ? bus1.busy     : bus0.busy;
        rdy = sel ? bus1.in_ready : bus0.in_ready;
    endtask

    task automatic chk_idle(input bit sel, input string tag);
        logic en, dn, bz, rdy;
        logic [2:0] wa;
        logic [5:0] din;
        snap(sel, en, wa, din, dn, bz, rdy);
        chk($sformatf("u%0d %s enter", sel, tag), 32'(en), 32'd0);
        chk($sformatf("u%0d %s done", sel, tag), 32'(dn), 32'd0);
        chk($sformatf("u%0d %s busy", sel, tag), 32'(bz), 32'd0);
        chk($sformatf("u%0d %s in_ready", sel, tag), 32'(rdy), 32'd1);
    endtask

    // Called at a falling edge; accept happens on the next rising edge (T0).
    // Checks every cycle from T0+1 up to and including the done cycle.
    task automatic run_word(input bit sel, input int hold, input logic [31:0] val,
                            input logic [7:0] dp, input logic [47:0] exp, input bit keep);
        logic en, dn, bz, rdy;
        logic [2:0] wa;
        logic [5:0] din;
        int last;
        int d;
        drive(sel, 1'b1, val, dp);
        @(posedge clk);
        last = 1 + 8 * (1 + hold);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if (keep) drive(sel, 1'b1, ~val, ~dp);
                else      drive(sel, 1'b0, 32'h0, 8'h0);
            end
            snap(sel, en, wa, din, dn, bz, rdy);
            d = (c == last) ? 7 : (c - 1) / (1 + hold);
            chk($sformatf("u%0d c%0d enter", sel, c), 32'(en),
                32'((c != last) && ((c - 1) % (1 + hold) == 0)));
            chk($sformatf("u%0d c%0d WADD", sel, c), 32'(wa), 32'(d));
            chk($sformatf("u%0d c%0d DIN", sel, c), 32'(din), 32'(exp[d*6 +: 6]));
            chk($sformatf("u%0d c%0d done", sel, c), 32'(dn), 32'(c == last));
            chk($sformatf("u%0d c%0d busy", sel, c), 32'(bz), 32'd1);
            chk($sformatf("u%0d c%0d in_ready", sel, c), 32'(rdy), 32'd0);
        end
    endtask

    initial begin
        logic [47:0] e_t1, e_t2, e_t3a, e_t3b, e_t5;
        logic en, dn, bz, rdy;
        logic [2:0] wa;
        logic [5:0] din;

        // Digit 0 occupies the low six bits.
        e_t1  = {6'h30, 6'h32, 6'h34, 6'h36, 6'h38, 6'h3A, 6'h3C, 6'h3E};
        e_t3b = {6'h31, 6'h33, 6'h35, 6'h37, 6'h39, 6'h3B, 6'h3D, 6'h3F};
`ifdef DISPLAY_WRITER_LZB_EN
        e_t2  = {6'h01, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h21};
        e_t3a = {6'h00, 6'h22, 6'h24, 6'h26, 6'h28, 6'h2A, 6'h2C, 6'h2E};
        e_t5  = {6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h22, 6'h24};
`else
        e_t2  = {6'h21, 6'h20, 6'h20, 6'h20, 6'h20, 6'h20, 6'h20, 6'h21};
        e_t3a = {6'h20, 6'h22, 6'h24, 6'h26, 6'h28, 6'h2A, 6'h2C, 6'h2E};
        e_t5  = {6'h20, 6'h20, 6'h20, 6'h20, 6'h20, 6'h20, 6'h22, 6'h24};
`endif

        rst_n0 = 1'b0;
        rst_n1 = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 8'h0);
        drive(1'b1, 1'b0, 32'h0, 8'h0);
        repeat (3) @(negedge clk);

        // Reset state of both instances
        for (int s = 0; s < 2; s++) begin
            snap(s[0], en, wa, din, dn, bz, rdy);
            chk($sformatf("u%0d rst WADD", s), 32'(wa), 32'd0);
            chk($sformatf("u%0d rst DIN", s), 32'(din), 32'd0);
            chk_idle(s[0], "rst");
        end
        rst_n0 = 1'b1;
        rst_n1 = 1'b1;
        @(negedge clk);

        // Test 1: full hex word, no decimal points
        run_word(1'b0, 1, 32'h89ABCDEF, 8'h00, e_t1, 1'b0);
        @(negedge clk);
        chk_idle(1'b0, "t1 after");

        // Test 2: zero value with outer decimal points
        run_word(1'b0, 1, 32'h00000000, 8'h81, e_t2, 1'b0);
        @(negedge clk);
        chk_idle(1'b0, "t2 after");

        // Test 3: in_valid held high with a different word while busy
        run_word(1'b0, 1, 32'h01234567, 8'h00, e_t3a, 1'b1);
        drive(1'b0, 1'b1, 32'h89ABCDEF, 8'hFF);
        @(negedge clk);
        snap(1'b0, en, wa, din, dn, bz, rdy);
        chk("u0 t3 gap in_ready", 32'(rdy), 32'd1);
        chk("u0 t3 gap enter", 32'(en), 32'd0);
        chk("u0 t3 gap done", 32'(dn), 32'd0);
        run_word(1'b0, 1, 32'h89ABCDEF, 8'hFF, e_t3b, 1'b0);
        @(negedge clk);
        chk_idle(1'b0, "t3 after");

        // Test 4: reset during the hold of digit 3
        drive(1'b0, 1'b1, 32'h89ABCDEF, 8'h00);
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) drive(1'b0, 1'b0, 32'h0, 8'h0);
        end
        snap(1'b0, en, wa, din, dn, bz, rdy);
        chk("u0 t4 pre enter", 32'(en), 32'd0);
        chk("u0 t4 pre WADD", 32'(wa), 32'd3);
        chk("u0 t4 pre DIN", 32'(din), 32'h38);
        rst_n0 = 1'b0;
        @(negedge clk);
        snap(1'b0, en, wa, din, dn, bz, rdy);
        chk("u0 t4 rst WADD", 32'(wa), 32'd0);
        chk("u0 t4 rst DIN", 32'(din), 32'd0);
        chk_idle(1'b0, "t4 rst");
        rst_n0 = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            snap(1'b0, en, wa, din, dn, bz, rdy);
            chk($sformatf("u0 t4 post%0d enter", c), 32'(en), 32'd0);
            chk($sformatf("u0 t4 post%0d done", c), 32'(dn), 32'd0);
        end

        // Test 5: longer hold on the second instance
        run_word(1'b1, 3, 32'h00000012, 8'h00, e_t5, 1'b0);
        @(negedge clk);
        chk_idle(1'b1, "t5 after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
